uart_rx_ext: RTL and testbench

Parametrised, runtime-configurable UART receiver, successor to the fixed 8-bit receiver in the serial subsystem.
- Adds 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits.
- Samples the line through a 2-flop synchronizer and takes a 3-sample majority vote per bit.
- Reports parity error, framing error and break per frame.
- Delivers frames over a valid/ready handshake with overrun signalling.

---
 rtl/uart_rx_ext.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ext
// Purpose  : Runtime-configurable UART receiver. Supports 5..DATA_W data bits,
//            optional even/odd parity and 1 or 2 stop bits. The line passes
//            through a 2-flop synchronizer, and each bit is decided by a
//            3-sample majority vote. Every frame carries parity-error,
//            framing-error and break flags and is delivered over a
//            valid/ready handshake with overrun signalling.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   bit_duration  clocks per bit (>= 4)
//   data_bits     data bits per frame, clamped to 5..DATA_W
//   parity_mode   00/11 none, 01 even, 10 odd
//   stop2         0 = one stop bit, 1 = two stop bits
//   m_data        received word, right-aligned, unused upper bits 0
//   m_valid       m_data and flags valid
//   m_ready       consumer accept
//   parity_err    parity mismatch (valid with m_valid)
//   frame_err     a stop bit sampled low (valid with m_valid)
//   break_det     break frame (valid with m_valid)
//   overrun       1-clk pulse: a frame was dropped because the last one is unaccepted
// ============================================================================
module uart_rx_ext #(
  parameter int DATA_W = 9,
  parameter int CTR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [CTR_W-1:0]  bit_duration,
  input  logic [3:0]        data_bits,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun
);

  localparam logic [3:0] c_max_bits = 4'(DATA_W);
  localparam logic [3:0] c_min_bits = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [2:0]          hist_q;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [CTR_W-1:0]    bd_q, bd_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [1:0]          par_q, par_d;
  logic                stop2_q, stop2_d;
  logic [3:0]          bitidx_q, bitidx_d;
  logic                stopidx_q, stopidx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                pzero_q, pzero_d;
  logic                ferr_q, ferr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                operr_q, operr_d;
  logic                oferr_q, oferr_d;
  logic                obrk_q, obrk_d;
  logic                ovr_q, ovr_d;

  logic                maj;
  logic                fall;
  logic                par_en;
  logic                tick;
  logic                half;
  logic [3:0]          nbits_clamped;
  logic                complete;
  logic                frame_perr;
  logic                frame_ferr;
  logic                frame_brk;

  assign maj    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  // hist_q[0] holds the previous synchronized sample, sync2_q the current one
  assign fall   = hist_q[0] & ~sync2_q;
  assign par_en = (par_q == 2'b01) || (par_q == 2'b10);
  assign tick   = (ctr_q == (bd_q - CTR_W'(1)));
  assign half   = (ctr_q == (bd_q >> 1));

  always_comb begin
    nbits_clamped = data_bits;
    if (data_bits < c_min_bits)      nbits_clamped = c_min_bits;
    else if (data_bits > c_max_bits) nbits_clamped = c_max_bits;
  end

  // Frame result as seen on the final stop sample (current maj included)
  assign frame_perr = par_en & perr_q;
  assign frame_ferr = ferr_q | ~maj;
  assign frame_brk  = ~maj & (shift_q == '0) & (~par_en | pzero_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 3'b111;
      ctr_q     <= '0;
      bd_q      <= '0;
      nbits_q   <= '0;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      bitidx_q  <= '0;
      stopidx_q <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      pzero_q   <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      operr_q   <= 1'b0;
      oferr_q   <= 1'b0;
      obrk_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      hist_q    <= {hist_q[1:0], sync2_q};
      ctr_q     <= ctr_d;
      bd_q      <= bd_d;
      nbits_q   <= nbits_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      bitidx_q  <= bitidx_d;
      stopidx_q <= stopidx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      pzero_q   <= pzero_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      operr_q   <= operr_d;
      oferr_q   <= oferr_d;
      obrk_q    <= obrk_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    bd_d      = bd_q;
    nbits_d   = nbits_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    bitidx_d  = bitidx_q;
    stopidx_d = stopidx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    pzero_d   = pzero_q;
    ferr_d    = ferr_q;
    complete  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d   = S_START;
          ctr_d     = '0;
          // Configuration is frozen here for the whole frame
          bd_d      = bit_duration;
          nbits_d   = nbits_clamped;
          par_d     = parity_mode;
          stop2_d   = stop2;
          bitidx_d  = '0;
          stopidx_d = 1'b0;
          shift_d   = '0;
          perr_d    = 1'b0;
          pzero_d   = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (half) begin
          ctr_d = '0;
          if (!maj) state_d = S_DATA;
          else      state_d = S_IDLE;
        end
      end
      S_DATA: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (tick) begin
          ctr_d = '0;
          for (int i = 0; i < DATA_W; i++) begin
            if (bitidx_q == 4'(i)) shift_d[i] = maj;
          end
          if (bitidx_q == (nbits_q - 4'd1)) begin
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bitidx_d = bitidx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (tick) begin
          ctr_d   = '0;
          // Odd parity expects an overall XOR of 1, even parity of 0
          perr_d  = ((^shift_q) ^ maj) != (par_q == 2'b10);
          pzero_d = ~maj;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (tick) begin
          ctr_d = '0;
          if (stop2_q && !stopidx_q) begin
            stopidx_d = 1'b1;
            if (!maj) ferr_d = 1'b1;
          end else begin
            complete = 1'b1;
            state_d  = frame_brk ? S_BRKWAIT : S_IDLE;
          end
        end
      end
      S_BRKWAIT: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register and handshake
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    obrk_d  = obrk_q;
    ovr_d   = 1'b0;
    if (valid_q && m_ready) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || m_ready) begin
        data_d  = shift_q;
        operr_d = frame_perr;
        oferr_d = frame_ferr;
        obrk_d  = frame_brk;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign parity_err = operr_q;
  assign frame_err  = oferr_q;
  assign break_det  = obrk_q;
  assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ext
// Purpose  : Self-checking bench for uart_rx_ext. Scenario tasks drive the
//            serial line and push expected frames into a scoreboard queue; a
//            monitor pops and compares on each accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

  localparam int DATA_W = 9;
  localparam int CTR_W  = 16;

  logic              clk;
  logic              rst;
  logic              rx;
  logic [CTR_W-1:0]  bit_duration;
  logic [3:0]        data_bits;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              parity_err;
  logic              frame_err;
  logic              break_det;
  logic              overrun;

  uart_rx_ext #(.DATA_W(DATA_W), .CTR_W(CTR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .bit_duration (bit_duration),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .overrun      (overrun)
  );

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int rise_cyc = 0;
  int ovr_cycles = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk;
    return e;
  endfunction

  // Monitor / scoreboard: sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (m_valid && !prev_valid) begin
      rises = rises + 1;
      rise_cyc = cyc;
    end
    prev_valid = m_valid;
    if (overrun) ovr_cycles = ovr_cycles + 1;
    if (m_valid && m_ready) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected: got data=%h pe=%b fe=%b bk=%b, expected no frame",
                 m_data, parity_err, frame_err, break_det);
      end else begin
        e = sb_q.pop_front();
        if ({m_data, parity_err, frame_err, break_det} !== {e.d, e.pe, e.fe, e.bk}) begin
          errors = errors + 1;
          $display("FAIL sb_frame: got data=%h pe=%b fe=%b bk=%b, expected data=%h pe=%b fe=%b bk=%b",
                   m_data, parity_err, frame_err, break_det, e.d, e.pe, e.fe, e.bk);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_bit(input int bd, input logic v, input bit spike);
    for (int c = 0; c < bd; c++) begin
      rx = (spike && c == bd / 2) ? 1'b0 : v;
      @(posedge clk); #1;
    end
  endtask

  // Caller must be aligned at posedge+1
  task automatic send_frame(input int bd, input int nb, input logic [8:0] d,
                            input bit has_par, input logic pb, input int nstop,
                            input logic s1v, input logic s2v, input int spike_bit);
    logic [8:0] dv;
    dv = d;
    start_cyc = cyc + 1;
    drive_bit(bd, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(bd, dv[i], (i == spike_bit));
    if (has_par) drive_bit(bd, pb, 1'b0);
    drive_bit(bd, s1v, 1'b0);
    if (nstop == 2) drive_bit(bd, s2v, 1'b0);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (sb_q.size() == 0) ok = 1'b1;
  endtask

  task automatic set_cfg(input int bd, input logic [3:0] db, input logic [1:0] pm, input logic s2);
    bit_duration = CTR_W'(bd);
    data_bits    = db;
    parity_mode  = pm;
    stop2        = s2;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b, expected 0", m_valid); end
    checks++; if (m_data !== 9'h000)   begin errors++; $display("FAIL rst_data: got %h, expected 000", m_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b, expected 0", parity_err); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_ferr: got %b, expected 0", frame_err); end
    checks++; if (break_det !== 1'b0)  begin errors++; $display("FAIL rst_brk: got %b, expected 0", break_det); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL rst_ovr: got %b, expected 0", overrun); end
    tick(20);
    checks++; if (rises !== 0) begin errors++; $display("FAIL rst_no_start: got %0d frames, expected 0", rises); end
  endtask

  task automatic test_8n1;
    int r0, lat;
    bit ok;
    r0 = rises;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    sb_q.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send_frame(16, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL 8n1_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(20);
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL 8n1_count: got %0d frames, expected 1", rises - r0); end
    lat = rise_cyc - start_cyc;
    checks++; if (lat < 154 || lat > 156) begin errors++; $display("FAIL 8n1_latency: got %0d clk, expected 155 +-1", lat); end
  endtask

  task automatic test_parity;
    bit ok;
    set_cfg(16, 4'd7, 2'b01, 1'b0);
    sb_q.push_back(mk(9'h041, 1'b1, 1'b0, 1'b0));
    send_frame(16, 7, 9'h041, 1'b1, 1'b1, 1, 1'b1, 1'b1, -1);
    tick(10);
    sb_q.push_back(mk(9'h041, 1'b0, 1'b0, 1'b0));
    send_frame(16, 7, 9'h041, 1'b1, 1'b0, 1, 1'b1, 1'b1, -1);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL par_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(10);
  endtask

  task automatic test_glitch;
    int r0;
    bit ok;
    r0 = rises;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    rx = 1'b0; tick(3); rx = 1'b1;
    tick(60);
    checks++; if (rises !== r0) begin errors++; $display("FAIL glitch_start: got %0d frames, expected 0", rises - r0); end
    sb_q.push_back(mk(9'h0FF, 1'b0, 1'b0, 1'b0));
    send_frame(16, 8, 9'h0FF, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL spike_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(10);
  endtask

  task automatic test_clamp;
    bit ok;
    // data_bits below the minimum behaves as 5
    set_cfg(16, 4'd3, 2'b00, 1'b0);
    sb_q.push_back(mk(9'h015, 1'b0, 1'b0, 1'b0));
    send_frame(16, 5, 9'h015, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    tick(10);
    // data_bits above DATA_W behaves as 9; odd parity, 2 stop bits
    set_cfg(16, 4'd15, 2'b10, 1'b1);
    sb_q.push_back(mk(9'h1AB, 1'b0, 1'b0, 1'b0));
    send_frame(16, 9, 9'h1AB, 1'b1, 1'b1, 2, 1'b1, 1'b1, -1);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(10);
  endtask

  task automatic test_frame_err;
    bit ok;
    set_cfg(16, 4'd8, 2'b00, 1'b1);
    sb_q.push_back(mk(9'h03C, 1'b0, 1'b1, 1'b0));
    send_frame(16, 8, 9'h03C, 1'b0, 1'b0, 2, 1'b1, 1'b0, -1);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ferr_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(30);
  endtask

  task automatic test_break;
    int r0;
    bit ok;
    r0 = rises;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    sb_q.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    rx = 1'b0;
    tick(20 * 16);
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL brk_count_low: got %0d frames, expected 1", rises - r0); end
    rx = 1'b1;
    tick(100);
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL brk_count_high: got %0d frames, expected 1", rises - r0); end
    wait_drain(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL brk_timeout: got %0d pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back;
    int o0;
    bit ok;
    o0 = ovr_cycles;
    m_ready = 1'b0;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    sb_q.push_back(mk(9'h011, 1'b0, 1'b0, 1'b0));
    send_frame(16, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    send_frame(16, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    tick(10);
    checks++; if (ovr_cycles - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d cycles, expected 1", ovr_cycles - o0); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_held_valid: got %b, expected 1", m_valid); end
    checks++; if (m_data !== 9'h011) begin errors++; $display("FAIL b2b_held_data: got %h, expected 011", m_data); end
    m_ready = 1'b1;
    tick(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid: got %b, expected 0", m_valid); end
    sb_q.push_back(mk(9'h033, 1'b0, 1'b0, 1'b0));
    send_frame(16, 8, 9'h033, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    wait_drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d pending, expected 0", sb_q.size()); end
    tick(10);
  endtask

  task automatic test_reset_midframe;
    int r0;
    m_ready = 1'b0;
    set_cfg(16, 4'd8, 2'b00, 1'b0);
    // Held word that the reset must discard (never pushed to the scoreboard)
    send_frame(16, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    tick(5);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstm_pending: got %b, expected 1", m_valid); end
    fork
      send_frame(16, 8, 9'h0F0, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
      begin
        tick(88);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid: got %b, expected 0", m_valid); end
      end
    join
    r0 = rises;
    m_ready = 1'b1;
    tick(300);
    checks++; if (rises !== r0) begin errors++; $display("FAIL rstm_spurious: got %0d frames, expected 0", rises - r0); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL rstm_sb: got %0d pending, expected 0", sb_q.size()); end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    bit_duration = 16'd16; data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_8n1;
    test_parity;
    test_glitch;
    test_clamp;
    test_frame_err;
    test_break;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
